// File: rtl/spi_slave_with_single_cs.sv
// SPI slave with a single chip select: synchronised SPI inputs, byte-wide RX/TX with a
// one-deep TX holding register, per-window byte counting and overflow/underrun flags.
module spi_slave_with_single_cs #(
    parameter int unsigned SPI_MODE         = 0,
    parameter int unsigned MAX_BYTES_PER_CS = 2,
    parameter int unsigned CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_SPI_Clk,
    input  logic          i_SPI_CS_n,
    input  logic          i_SPI_MOSI,
    output logic          o_SPI_MISO,
    output logic          o_SPI_MISO_En,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic [7:0]    o_RX_Byte,
    output logic          o_RX_DV,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_TX_Underrun,
    output logic          o_Overflow
);
    localparam logic          Cpol     = ((SPI_MODE >> 1) & 1) != 0;
    localparam logic          Cpha     = (SPI_MODE & 1) != 0;
    localparam logic [CW-1:0] MaxCount = CW'(MAX_BYTES_PER_CS);

    typedef enum logic [1:0] {StIdle, StSelected, StWaitDeselect} state_e;

    logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q, cs_prev_q;

    always_ff @(posedge i_Clk) begin
        sck_sync_q  <= {sck_sync_q[0], i_SPI_Clk};
        cs_sync_q   <= {cs_sync_q[0], i_SPI_CS_n};
        mosi_sync_q <= {mosi_sync_q[0], i_SPI_MOSI};
        sck_prev_q  <= sck_sync_q[1];
        cs_prev_q   <= cs_sync_q[1];
    end

    logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, lead_edge, trail_edge;
    logic sample_edge, drive_edge, cs_fall;

    assign sck_s       = sck_sync_q[1];
    assign cs_s        = cs_sync_q[1];
    assign mosi_s      = mosi_sync_q[1];
    assign sck_rise    = sck_s & ~sck_prev_q;
    assign sck_fall    = ~sck_s & sck_prev_q;
    assign lead_edge   = Cpol ? sck_fall : sck_rise;
    assign trail_edge  = Cpol ? sck_rise : sck_fall;
    assign sample_edge = Cpha ? trail_edge : lead_edge;
    assign drive_edge  = Cpha ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_q & ~cs_s;

    state_e        state_q, state_d;
    logic [7:0]    rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic [7:0]    tx_shift_q, tx_shift_d, hold_q, hold_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [CW-1:0] rx_count_q, rx_count_d;
    logic          rx_dv_q, rx_dv_d, overflow_q, overflow_d, underrun_q, underrun_d;
    logic          tx_fresh_q, tx_fresh_d, miso_q, miso_d, hold_full_q, hold_full_d;
    logic          bnd_entry, bnd_mid, tx_accept;
    logic [7:0]    tx_next;

    always_comb begin
        state_d     = state_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        bit_cnt_d   = bit_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        rx_count_d  = rx_count_q;
        rx_dv_d     = 1'b0;
        overflow_d  = overflow_q;
        underrun_d  = 1'b0;
        tx_fresh_d  = tx_fresh_q;
        miso_d      = miso_q;
        hold_full_d = hold_full_q;
        bnd_entry   = 1'b0;
        bnd_mid     = 1'b0;
        tx_next     = 8'hFF;
        tx_accept   = i_TX_DV & ~hold_full_q;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StSelected;
                    bnd_entry  = 1'b1;
                    bit_cnt_d  = '0;
                    tx_cnt_d   = '0;
                    rx_shift_d = '0;
                    tx_fresh_d = 1'b1;
                    miso_d     = 1'b1;
                end
            end
            StSelected: begin
                if (cs_s) begin
                    state_d    = StIdle;
                    bit_cnt_d  = '0;
                    rx_count_d = '0;
                    overflow_d = 1'b0;
                    rx_shift_d = '0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[6:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_count_q < MaxCount) begin
                                rx_byte_d  = {rx_shift_q[6:0], mosi_s};
                                rx_dv_d    = 1'b1;
                                rx_count_d = rx_count_q + CW'(1);
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end
                    if (drive_edge) begin
                        tx_cnt_d = tx_cnt_q + 3'd1;
                        if (Cpha) begin
                            // The first byte was loaded on entry; later bytes load on bit 0.
                            if (tx_cnt_q == 3'd0 && !tx_fresh_q) begin
                                bnd_mid = 1'b1;
                            end else begin
                                miso_d     = tx_shift_q[7];
                                tx_shift_d = {tx_shift_q[6:0], 1'b1};
                            end
                            tx_fresh_d = 1'b0;
                        end else if (tx_cnt_q == 3'd7) begin
                            bnd_mid = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b1};
                        end
                    end
                end
            end
            StWaitDeselect: begin
                if (cs_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A byte written in the boundary cycle counts as on time: no underrun is flagged.
        if (bnd_entry || bnd_mid) begin
            tx_next     = hold_full_q ? hold_q : 8'hFF;
            underrun_d  = ~hold_full_q & ~tx_accept;
            hold_full_d = 1'b0;
            if (Cpha && bnd_mid) begin
                miso_d     = tx_next[7];
                tx_shift_d = {tx_next[6:0], 1'b1};
            end else begin
                tx_shift_d = tx_next;
            end
        end
        if (tx_accept) begin
            hold_d      = i_TX_Byte;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q     <= cs_s ? StIdle : StWaitDeselect;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            bit_cnt_q   <= '0;
            tx_cnt_q    <= '0;
            rx_count_q  <= '0;
            rx_dv_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            tx_fresh_q  <= 1'b0;
            miso_q      <= 1'b1;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_count_q  <= rx_count_d;
            rx_dv_q     <= rx_dv_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
            tx_fresh_q  <= tx_fresh_d;
            miso_q      <= miso_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign o_SPI_MISO    = (state_q == StSelected) ? (Cpha ? miso_q : tx_shift_q[7]) : 1'b1;
    assign o_SPI_MISO_En = (state_q == StSelected);
    assign o_TX_Ready    = ~hold_full_q;
    assign o_RX_Byte     = rx_byte_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_RX_Count    = rx_count_q;
    assign o_TX_Underrun = underrun_q;
    assign o_Overflow    = overflow_q;
endmodule

// File: tb/tb_spi_slave_with_single_cs.sv
// Bench for spi_slave_with_single_cs: one DUT per SPI mode, a bit-banged master per DUT and a
// frame-level model of the TX holding register and RX byte counting.
module tb_spi_slave_with_single_cs;
    localparam int Half = 8;
    localparam int Max  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sck [4];
    logic       cs_n [4];
    logic       mosi [4];
    logic       miso [4];
    logic       miso_en [4];
    logic [7:0] tx_byte [4];
    logic       tx_dv [4];
    logic       tx_ready [4];
    logic [7:0] rx_byte [4];
    logic       rx_dv [4];
    logic [1:0] rx_cnt [4];
    logic       und [4];
    logic       ovf [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_with_single_cs #(
            .SPI_MODE(g),
            .MAX_BYTES_PER_CS(Max)
        ) u_dut (
            .i_Clk        (clk),
            .i_Rst_L      (rst_n),
            .i_SPI_Clk    (sck[g]),
            .i_SPI_CS_n   (cs_n[g]),
            .i_SPI_MOSI   (mosi[g]),
            .o_SPI_MISO   (miso[g]),
            .o_SPI_MISO_En(miso_en[g]),
            .i_TX_Byte    (tx_byte[g]),
            .i_TX_DV      (tx_dv[g]),
            .o_TX_Ready   (tx_ready[g]),
            .o_RX_Byte    (rx_byte[g]),
            .o_RX_DV      (rx_dv[g]),
            .o_RX_Count   (rx_cnt[g]),
            .o_TX_Underrun(und[g]),
            .o_Overflow   (ovf[g])
        );
    end

    int         n_checks = 0;
    int         n_fail = 0;
    int         dv_cnt [4] = '{0, 0, 0, 0};
    int         und_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] rx_log [4][64];
    logic [7:0] m_hold [4];
    bit         m_full [4];

    // Count every cycle the pulses are high so a stuck pulse shows up as extra events.
    always begin
        @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            if (rx_dv[m] === 1'b1) begin
                rx_log[m][dv_cnt[m] % 64] = rx_byte[m];
                dv_cnt[m]++;
            end
            if (und[m] === 1'b1) und_cnt[m]++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int m, input logic [7:0] b);
        @(negedge clk);
        check_eq($sformatf("ready_pre_m%0d", m), 32'(tx_ready[m]), 32'(!m_full[m]));
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        @(negedge clk);
        tx_dv[m] = 1'b0;
        if (!m_full[m]) begin
            m_hold[m] = b;
            m_full[m] = 1'b1;
        end
        check_eq($sformatf("ready_post_m%0d", m), 32'(tx_ready[m]), 32'd0);
    endtask

    task automatic half_wait(input int m, input bit inj, input logic [7:0] b);
        if (inj) begin
            // Strobe lands in the cycle the synchronised SCK edge is acted on.
            repeat (2) @(negedge clk);
            tx_byte[m] = b;
            tx_dv[m]   = 1'b1;
            @(negedge clk);
            tx_dv[m] = 1'b0;
            repeat (Half - 3) @(negedge clk);
        end else begin
            repeat (Half) @(negedge clk);
        end
    endtask

    task automatic spi_frame(input int m, input int n, input logic [7:0] mo [4],
                             output logic [7:0] mi [4], input int inj_edge,
                             input logic [7:0] inj_byte);
        logic cpol, cpha;
        int   e;
        cpol = (m & 2) != 0;
        cpha = (m & 1) != 0;
        e    = 0;
        for (int k = 0; k < 4; k++) mi[k] = '0;
        cs_n[m] = 1'b0;
        if (!cpha) mosi[m] = mo[0][7];
        repeat (Half) @(negedge clk);
        for (int b = 0; b < n; b++) begin
            for (int i = 7; i >= 0; i--) begin
                if (cpha) begin
                    sck[m]  = ~cpol;
                    mosi[m] = mo[b][i];
                    half_wait(m, e == inj_edge, inj_byte);
                    e++;
                    mi[b][i] = miso[m];
                    sck[m]   = cpol;
                    repeat (Half) @(negedge clk);
                end else begin
                    mi[b][i] = miso[m];
                    sck[m]   = ~cpol;
                    repeat (Half) @(negedge clk);
                    sck[m] = cpol;
                    if (i > 0) mosi[m] = mo[b][i-1];
                    else if (b + 1 < n) mosi[m] = mo[b+1][7];
                    half_wait(m, e == inj_edge, inj_byte);
                    e++;
                end
            end
        end
    endtask

    task automatic cs_release(input int m);
        cs_n[m] = 1'b1;
        repeat (2 * Half) @(negedge clk);
    endtask

    // Boundaries per frame: one on selection, then one per completed byte for CPHA=0 or one
    // per further byte for CPHA=1. Each consumes the holding byte or substitutes FF.
    task automatic model_frame(input int m, input int n, output logic [7:0] exp_tx [4],
                               output int exp_und);
        int         nb;
        logic [7:0] v;
        nb      = ((m & 1) != 0) ? n : n + 1;
        exp_und = 0;
        for (int k = 0; k < 4; k++) exp_tx[k] = 8'hFF;
        for (int k = 0; k < nb; k++) begin
            if (m_full[m]) begin
                v         = m_hold[m];
                m_full[m] = 1'b0;
            end else begin
                v = 8'hFF;
                exp_und++;
            end
            if (k < n) exp_tx[k] = v;
        end
    endtask

    task automatic run_exchange(input int m, input int n, input logic [7:0] mo [4],
                                input string tag);
        logic [7:0] mi [4];
        logic [7:0] exp_tx [4];
        int         exp_und, dv0, und0, nrx;
        model_frame(m, n, exp_tx, exp_und);
        dv0 = dv_cnt[m];
        und0 = und_cnt[m];
        spi_frame(m, n, mo, mi, -1, 8'h00);
        nrx = (n < Max) ? n : Max;
        check_eq({tag, "_en"}, 32'(miso_en[m]), 32'd1);
        for (int k = 0; k < n; k++)
            check_eq($sformatf("%s_miso%0d", tag, k), 32'(mi[k]), 32'(exp_tx[k]));
        check_eq({tag, "_dvs"}, 32'(dv_cnt[m] - dv0), 32'(nrx));
        for (int k = 0; k < nrx; k++)
            check_eq($sformatf("%s_rx%0d", tag, k), 32'(rx_log[m][(dv0 + k) % 64]), 32'(mo[k]));
        check_eq({tag, "_cnt"}, 32'(rx_cnt[m]), 32'(nrx));
        check_eq({tag, "_ovf"}, 32'(ovf[m]), 32'(n > Max));
        check_eq({tag, "_und"}, 32'(und_cnt[m] - und0), 32'(exp_und));
        cs_release(m);
        check_eq({tag, "_cnt_clr"}, 32'(rx_cnt[m]), 32'd0);
        check_eq({tag, "_ovf_clr"}, 32'(ovf[m]), 32'd0);
        check_eq({tag, "_en_off"}, 32'(miso_en[m]), 32'd0);
    endtask

    initial begin
        logic [7:0] mo [4];
        logic [7:0] mi [4];
        int         dv0, und0, m, n;

        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sck[k]     = (k & 2) != 0;
            cs_n[k]    = 1'b1;
            mosi[k]    = 1'b0;
            tx_byte[k] = '0;
            tx_dv[k]   = 1'b0;
            m_hold[k]  = '0;
            m_full[k]  = 1'b0;
        end
        repeat (6) @(negedge clk);
        check_eq("rst_miso", 32'(miso[0]), 32'd1);
        check_eq("rst_rxbyte", 32'(rx_byte[0]), 32'd0);
        check_eq("rst_rxdv", 32'(rx_dv[0]), 32'd0);
        check_eq("rst_rxcnt", 32'(rx_cnt[0]), 32'd0);
        check_eq("rst_und", 32'(und[0]), 32'd0);
        check_eq("rst_ovf", 32'(ovf[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("rst_en_m%0d", k), 32'(miso_en[k]), 32'd0);
            check_eq($sformatf("rst_ready_m%0d", k), 32'(tx_ready[k]), 32'd1);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic exchange in every mode.
        load(0, 8'hA5);
        mo = '{8'h3C, 8'h00, 8'h00, 8'h00};
        run_exchange(0, 1, mo, "mode0");
        for (int k = 1; k < 4; k++) begin
            load(k, 8'h7E);
            mo = '{8'h81, 8'h00, 8'h00, 8'h00};
            run_exchange(k, 1, mo, $sformatf("mode%0d", k));
        end

        // Three bytes in one window against a limit of two.
        load(0, 8'h12);
        mo = '{8'h01, 8'h02, 8'h03, 8'h00};
        run_exchange(0, 3, mo, "ovf");

        // Nothing loaded: every slot returns FF.
        mo = '{8'hC0, 8'hDE, 8'h00, 8'h00};
        run_exchange(1, 2, mo, "undr_m1");
        run_exchange(0, 2, mo, "undr_m0");

        // A strobe while the holding register is full is dropped.
        load(2, 8'h11);
        load(2, 8'h22);
        mo = '{8'h5A, 8'h00, 8'h00, 8'h00};
        run_exchange(2, 1, mo, "drop");

        // Strobe coincident with the second-byte boundary in mode 1.
        load(1, 8'hC3);
        m_full[1] = 1'b0;
        dv0 = dv_cnt[1];
        und0 = und_cnt[1];
        mo = '{8'h44, 8'h99, 8'h00, 8'h00};
        spi_frame(1, 2, mo, mi, 8, 8'h96);
        check_eq("coinc_miso0", 32'(mi[0]), 32'hC3);
        check_eq("coinc_miso1", 32'(mi[1]), 32'hFF);
        check_eq("coinc_und", 32'(und_cnt[1] - und0), 32'd0);
        check_eq("coinc_dvs", 32'(dv_cnt[1] - dv0), 32'd2);
        check_eq("coinc_ready", 32'(tx_ready[1]), 32'd0);
        cs_release(1);
        check_eq("coinc_ready_idle", 32'(tx_ready[1]), 32'd0);
        m_hold[1] = 8'h96;
        m_full[1] = 1'b1;
        mo = '{8'h3E, 8'h00, 8'h00, 8'h00};
        run_exchange(1, 1, mo, "coinc_next");

        // Reset mid-byte with CS held low: nothing is received until CS cycles.
        dv0 = dv_cnt[0];
        cs_n[0] = 1'b0;
        repeat (Half) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi[0] = i[0];
            sck[0] = 1'b1;
            repeat (Half) @(negedge clk);
            sck[0] = 1'b0;
            repeat (Half) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) m_full[k] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mosi[0] = ~mosi[0];
            sck[0] = 1'b1;
            repeat (Half) @(negedge clk);
            sck[0] = 1'b0;
            repeat (Half) @(negedge clk);
        end
        check_eq("rstcs_dvs", 32'(dv_cnt[0] - dv0), 32'd0);
        check_eq("rstcs_en", 32'(miso_en[0]), 32'd0);
        check_eq("rstcs_cnt", 32'(rx_cnt[0]), 32'd0);
        cs_release(0);
        mo = '{8'h55, 8'h00, 8'h00, 8'h00};
        run_exchange(0, 1, mo, "rstcs_after");
        check_eq("rstcs_rxbyte", 32'(rx_byte[0]), 32'h55);

        // Randomised frames across modes, lengths and preload choices.
        for (int it = 0; it < 14; it++) begin
            m = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) load(m, 8'($urandom));
            for (int k = 0; k < 4; k++) mo[k] = 8'($urandom);
            run_exchange(m, n, mo, $sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
